// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/state enums, stage codes and instruction field slices for core_ctrl_seq
package ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_MOV  = 3'b001,
      OP_MOVI = 3'b010,
      OP_LD   = 3'b011,
      OP_ST   = 3'b100,
      OP_LEA  = 3'b101,
      OP_ALU  = 3'b110,
      OP_HALT = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE, FETCH, IMM, READ, EXEC, MEM, WB, HALTED
   } state_e;

   localparam logic [1:0] STG_READ = 2'b00;
   localparam logic [1:0] STG_EXEC = 2'b01;
   localparam logic [1:0] STG_MEM  = 2'b10;
   localparam logic [1:0] STG_WB   = 2'b11;

   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;
   localparam int RD_MSB = 5;
   localparam int RD_LSB = 3;
   localparam int RS_MSB = 2;
   localparam int RS_LSB = 0;

   typedef struct packed {
      logic mode;
      logic lea;
      logic reg_to_reg;
      logic mem_to_reg;
      logic reg_to_mem;
      logic wb_en;
      logic is_mem;
      logic is_store;
   } dec_t;

endpackage

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - opcode to register-file control decode; ungated, the sequencer qualifies by state
module inst_decode
   import ctrl_pkg::*;
(
   input  opcode_e opcode_i,
   output dec_t    dec_o
);

   always_comb begin
      dec_o = '0;
      case (opcode_i)
         OP_MOV: begin
            dec_o.reg_to_reg = 1'b1;
            dec_o.wb_en      = 1'b1;
         end
         OP_MOVI: begin
            dec_o.reg_to_reg = 1'b1;
            dec_o.mode       = 1'b1;
            dec_o.wb_en      = 1'b1;
         end
         OP_LD: begin
            dec_o.mem_to_reg = 1'b1;
            dec_o.wb_en      = 1'b1;
            dec_o.is_mem     = 1'b1;
         end
         OP_ST: begin
            dec_o.reg_to_mem = 1'b1;
            dec_o.is_mem     = 1'b1;
            dec_o.is_store   = 1'b1;
         end
         OP_LEA: begin
            dec_o.lea   = 1'b1;
            dec_o.wb_en = 1'b1;
         end
         OP_ALU:  dec_o.wb_en = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/core_ctrl_seq.sv
// rtl/core_ctrl_seq.sv - multi-cycle control sequencer; CTRL_MEM_TIMEOUT_EN adds the mem_ack wait timeout
module core_ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int INST_W      = 9,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [PC_W-1:0]   pc_out,
   input  logic [INST_W-1:0] inst_in,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic [1:0]        stage,
   output logic              mode,
   output logic              lea,
   output logic [2:0]        reg_dest,
   output logic [2:0]        reg_src,
   output logic [7:0]        immediate,
   output logic              write_enable,
   output logic              regToReg,
   output logic              memToReg,
   output logic              regToMem,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INST_W-1:0]   ir_q, ir_d;
   logic [7:0]          imm_q, imm_d;
   opcode_e             fetch_op;
   dec_t                dec;
   logic                active;

`ifdef CTRL_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   assign fetch_op = opcode_e'(inst_in[OP_MSB:OP_LSB]);

   inst_decode u_dec (
      .opcode_i (opcode_e'(ir_q[OP_MSB:OP_LSB])),
      .dec_o    (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         imm_q   <= '0;
`ifdef CTRL_MEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         imm_q   <= imm_d;
`ifdef CTRL_MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      imm_d   = imm_q;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE, HALTED: begin
            if (start) begin
               state_d = FETCH;
               pc_d    = '0;
`ifdef CTRL_MEM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         FETCH: begin
            ir_d = inst_in;
            // HALT keeps pc on its own address so done reports where it stopped
            if (fetch_op == OP_HALT) begin
               state_d = HALTED;
            end else begin
               pc_d    = pc_q + PC_W'(1);
               state_d = (fetch_op == OP_MOVI) ? IMM : READ;
            end
         end
         IMM: begin
            imm_d   = inst_in[7:0];
            pc_d    = pc_q + PC_W'(1);
            state_d = READ;
         end
         READ: state_d = EXEC;
         EXEC: begin
            state_d = dec.is_mem ? MEM : WB;
`ifdef CTRL_MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         MEM: begin
            if (mem_ack) begin
               state_d = WB;
`ifdef CTRL_MEM_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               state_d = HALTED;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         WB:      state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      active = (state_q == READ) || (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
      case (state_q)
         READ:    stage = STG_READ;
         EXEC:    stage = STG_EXEC;
         MEM:     stage = STG_MEM;
         default: stage = STG_WB;
      endcase
      mem_req      = (state_q == MEM);
      mem_we       = (state_q == MEM) && dec.is_store;
      mode         = active && dec.mode;
      lea          = active && dec.lea;
      regToReg     = active && dec.reg_to_reg;
      memToReg     = active && dec.mem_to_reg;
      regToMem     = active && dec.reg_to_mem;
      write_enable = (state_q == WB) && dec.wb_en;
      reg_dest     = active ? ir_q[RD_MSB:RD_LSB] : 3'd0;
      reg_src      = active ? ir_q[RS_MSB:RS_LSB] : 3'd0;
      immediate    = (active && dec.mode) ? imm_q : 8'd0;
      busy         = (state_q != IDLE) && (state_q != HALTED);
      done         = (state_q == HALTED);
      pc_out       = pc_q;
   end

`ifdef CTRL_MEM_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_core_ctrl_seq.sv
// tb/tb_core_ctrl_seq.sv - vector table, randomized trace model and corner sequences for core_ctrl_seq
module tb_core_ctrl_seq;

   localparam logic [8:0] HALT_W = 9'h1C0;

   logic       clk = 1'b0;
   logic       rst_n, start, mem_ack;
   logic [7:0] pc_out;
   logic [8:0] inst_in;
   logic       mem_req, mem_we, mode, lea, write_enable, regToReg, memToReg, regToMem;
   logic       busy, done, err;
   logic [1:0] stage;
   logic [2:0] reg_dest, reg_src;
   logic [7:0] immediate;

   logic [8:0] rom [256];
   int         dq[$];
   int         mdl_dly[$];
   bit         ack_auto, in_mem;
   int         cur_delay, wcnt;
   int         n_tests = 0, n_fail = 0;

   typedef struct packed {
      logic [1:0] stage;
      logic busy, done, err, mem_req, mem_we, we, r2r, m2r, r2m, lea, mode;
      logic [2:0] rd, rs;
      logic [7:0] imm, pc;
   } obs_t;

   typedef struct packed {
      logic we, r2r, mode, m2r, r2m, lea;
      logic [2:0] rd, rs;
      logic [7:0] imm;
   } snap_t;

   typedef struct {
      logic [8:0]  inst;
      logic [8:0]  word;
      int          dly;
      int          busy_n;
      logic [31:0] stg;
      int          memreq_n;
      logic        memwe;
      snap_t       snap;
      logic [7:0]  pc_done;
   } vec_t;

   obs_t exp_q[$];

   core_ctrl_seq #(.PC_W(8), .INST_W(9), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pc_out(pc_out), .inst_in(inst_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .stage(stage),
      .mode(mode), .lea(lea), .reg_dest(reg_dest), .reg_src(reg_src),
      .immediate(immediate), .write_enable(write_enable), .regToReg(regToReg),
      .memToReg(memToReg), .regToMem(regToMem), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   assign inst_in = rom[pc_out];

   // memory model: acks after a per-request delay taken from dq
   always @(negedge clk) begin
      if (mem_req && ack_auto) begin
         if (!in_mem) begin
            in_mem    = 1'b1;
            cur_delay = (dq.size() > 0) ? dq.pop_front() : 0;
            wcnt      = 0;
         end
         mem_ack = (wcnt == cur_delay);
         wcnt++;
      end else begin
         in_mem  = 1'b0;
         mem_ack = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.stage = stage;   o.busy = busy;     o.done = done;       o.err = err;
      o.mem_req = mem_req; o.mem_we = mem_we; o.we = write_enable;
      o.r2r = regToReg;  o.m2r = memToReg;  o.r2m = regToMem;    o.lea = lea;
      o.mode = mode;     o.rd = reg_dest;   o.rs = reg_src;      o.imm = immediate;
      o.pc = pc_out;
      return o;
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = HALT_W;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expected per-cycle trace built from the instruction semantics, starting at FETCH of address 0.
   task automatic build_trace();
      obs_t       o, base;
      int         a, op, d, guard;
      int         dl[$];
      logic [8:0] w;
      dl = mdl_dly;
      exp_q.delete();
      a = 0;
      guard = 0;
      while (guard < 600) begin
         guard++;
         w  = rom[a];
         op = int'(w[8:6]);
         o = '0; o.stage = 2'b11; o.busy = 1'b1; o.pc = 8'(a);
         exp_q.push_back(o);
         if (op == 7) begin
            o.busy = 1'b0; o.done = 1'b1;
            exp_q.push_back(o);
            break;
         end
         a = (a + 1) % 256;
         base = '0;
         base.busy = 1'b1;
         base.rd   = w[5:3];
         base.rs   = w[2:0];
         base.r2r  = (op == 1 || op == 2);
         base.mode = (op == 2);
         base.m2r  = (op == 3);
         base.r2m  = (op == 4);
         base.lea  = (op == 5);
         if (op == 2) begin
            o.pc = 8'(a);
            exp_q.push_back(o);
            base.imm = rom[a][7:0];
            a = (a + 1) % 256;
         end
         base.pc = 8'(a);
         o = base; o.stage = 2'b00; exp_q.push_back(o);
         o = base; o.stage = 2'b01; exp_q.push_back(o);
         if (op == 3 || op == 4) begin
            d = (dl.size() > 0) ? dl.pop_front() : 0;
            for (int k = 0; k <= d; k++) begin
               o = base; o.stage = 2'b10; o.mem_req = 1'b1; o.mem_we = (op == 4);
               exp_q.push_back(o);
            end
         end
         o = base; o.stage = 2'b11;
         o.we = (op == 1 || op == 2 || op == 3 || op == 5 || op == 6);
         exp_q.push_back(o);
      end
   endtask

   initial begin
      vec_t       vec[10];
      int         busy_n, memreq_n, a, op, c;
      logic       memwe_seen;
      logic [31:0] stg;
      logic [1:0] prev;
      snap_t      snap;
      logic [8:0] w;
      obs_t       rst_exp;

      vec[0] = '{9'h088, 9'h05A, 0, 6, 32'hF1F,   0, 1'b0, snap_t'({6'b111000, 3'd1, 3'd0, 8'h5A}), 8'd2};
      vec[1] = '{9'h051, HALT_W, 0, 5, 32'h31F,   0, 1'b0, snap_t'({6'b110000, 3'd2, 3'd1, 8'h00}), 8'd1};
      vec[2] = '{9'h0DC, HALT_W, 3, 9, 32'h31AAF, 4, 1'b0, snap_t'({6'b100100, 3'd3, 3'd4, 8'h00}), 8'd1};
      vec[3] = '{9'h12E, HALT_W, 0, 6, 32'hC6F,   1, 1'b1, snap_t'({6'b000010, 3'd5, 3'd6, 8'h00}), 8'd1};
      vec[4] = '{9'h000, HALT_W, 0, 5, 32'h31F,   0, 1'b0, snap_t'({6'b000000, 3'd0, 3'd0, 8'h00}), 8'd1};
      vec[5] = '{9'h178, HALT_W, 0, 5, 32'h31F,   0, 1'b0, snap_t'({6'b100001, 3'd7, 3'd0, 8'h00}), 8'd1};
      vec[6] = '{9'h1A2, HALT_W, 0, 5, 32'h31F,   0, 1'b0, snap_t'({6'b100000, 3'd4, 3'd2, 8'h00}), 8'd1};
      vec[7] = '{HALT_W, HALT_W, 0, 1, 32'h3,     0, 1'b0, snap_t'(20'h0),                          8'd0};
      vec[8] = '{9'h0C9, HALT_W, 0, 6, 32'hC6F,   1, 1'b0, snap_t'({6'b100100, 3'd1, 3'd1, 8'h00}), 8'd1};
      vec[9] = '{9'h0B8, 9'h1FF, 0, 6, 32'hF1F,   0, 1'b0, snap_t'({6'b111000, 3'd7, 3'd0, 8'hFF}), 8'd2};

      rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; ack_auto = 1'b1;
      clear_rom();
      repeat (3) @(negedge clk);
      rst_exp = '0; rst_exp.stage = 2'b11;
      chk("reset_outputs", 64'(sample()), 64'(rst_exp));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_holds", 64'(sample()), 64'(rst_exp));

      // table-driven single instructions followed by HALT
      for (int i = 0; i < 10; i++) begin
         clear_rom();
         rom[0] = vec[i].inst;
         if (vec[i].inst[8:6] == 3'b010) rom[1] = vec[i].word;
         dq.delete();
         dq.push_back(vec[i].dly);
         busy_n = 0; memreq_n = 0; memwe_seen = 1'b0; stg = '0; snap = '0; prev = 2'b11;
         do_start();
         for (int k = 0; k < 40 && !done; k++) begin
            if (busy) begin busy_n++; stg = {stg[29:0], stage}; end
            if (mem_req) memreq_n++;
            if (mem_we) memwe_seen = 1'b1;
            if (stage == 2'b11 && (prev == 2'b01 || prev == 2'b10))
               snap = {write_enable, regToReg, mode, memToReg, regToMem, lea, reg_dest, reg_src, immediate};
            prev = stage;
            @(negedge clk);
         end
         chk($sformatf("v%0d_done", i), 64'(done), 64'(1));
         chk($sformatf("v%0d_cycles", i), 64'(busy_n), 64'(vec[i].busy_n));
         chk($sformatf("v%0d_stages", i), 64'(stg), 64'(vec[i].stg));
         chk($sformatf("v%0d_memreq_cycles", i), 64'(memreq_n), 64'(vec[i].memreq_n));
         chk($sformatf("v%0d_mem_we", i), 64'(memwe_seen), 64'(vec[i].memwe));
         chk($sformatf("v%0d_wb_controls", i), 64'(snap), 64'(vec[i].snap));
         chk($sformatf("v%0d_halt_pc", i), 64'(pc_out), 64'(vec[i].pc_done));
         chk($sformatf("v%0d_err", i), 64'(err), 64'(0));
      end

      // randomized programs against the trace model, with stray start pulses while busy
      for (int p = 0; p < 4; p++) begin
         clear_rom();
         mdl_dly.delete(); dq.delete();
         a = 0;
         for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 6));
            w = {op[2:0], 6'($urandom)};
            rom[a] = w; a++;
            if (op == 2) begin rom[a] = 9'($urandom); a++; end
            if (op == 3 || op == 4) begin
               c = int'($urandom_range(0, 3));
               mdl_dly.push_back(c); dq.push_back(c);
            end
         end
         build_trace();
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         while (exp_q.size() > 0) begin
            start = (exp_q.size() > 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            chk($sformatf("rand%0d_trace", p), 64'(sample()), 64'(exp_q.pop_front()));
            @(negedge clk);
         end
         start = 1'b0;
      end

      // asynchronous reset while waiting in MEM, then re-run from pc 0
      clear_rom(); rom[0] = 9'h0DC;
      ack_auto = 1'b0;
      do_start();
      for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("mem_wait_req", 64'(mem_req), 64'(1));
      chk("mem_wait_err", 64'(err), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mid_mem_stage", 64'(stage), 64'(3));
      chk("rst_mid_mem_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      ack_auto = 1'b1;
      dq.delete();
      do_start();
      chk("restart_pc", 64'(pc_out), 64'(0));
      chk("restart_busy", 64'(busy), 64'(1));
      for (int k = 0; k < 20 && !done; k++) @(negedge clk);
      chk("restart_done", 64'(done), 64'(1));
      chk("restart_pc_end", 64'(pc_out), 64'(1));

`ifdef CTRL_MEM_TIMEOUT_EN
      ack_auto = 1'b0;
      do_start();
      memreq_n = 0;
      for (int k = 0; k < 30 && !done; k++) begin
         if (mem_req) memreq_n++;
         @(negedge clk);
      end
      chk("tmo_done", 64'(done), 64'(1));
      chk("tmo_mem_cycles", 64'(memreq_n), 64'(4));
      chk("tmo_err", 64'(err), 64'(1));
      chk("tmo_mem_req", 64'(mem_req), 64'(0));
      repeat (2) @(negedge clk);
      chk("tmo_err_sticky", 64'(err), 64'(1));
      ack_auto = 1'b1;
      do_start();
      chk("tmo_start_clears_err", 64'(err), 64'(0));
      for (int k = 0; k < 20 && !done; k++) @(negedge clk);
      chk("tmo_rerun_err", 64'(err), 64'(0));
`endif

      // pc wrap: NOPs everywhere, HALT appears at 0 only once pc has reached 255
      for (int i = 0; i < 256; i++) rom[i] = 9'h000;
      do_start();
      for (int k = 0; k < 1200 && pc_out != 8'hFF; k++) @(negedge clk);
      chk("wrap_reach_ff", 64'(pc_out), 64'(8'hFF));
      rom[0] = HALT_W;
      for (int k = 0; k < 20 && !done; k++) @(negedge clk);
      chk("wrap_done", 64'(done), 64'(1));
      chk("wrap_pc", 64'(pc_out), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
